// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V write-back pipeline stage with load alignment
//
// Purpose: registers the MEM/WB slot, aligns and extends load data, selects
//          the register-file write value and (optionally) counts retirements.
// Optional feature macro: WB_RETIRE_CNT_EN (adds the instret port and counter).
// Ports:
//   clk, reset (sync, active-low)
//   mem_valid, stall, flush                 - slot control
//   mem_reg_write, mem_rd, mem_wb_sel       - write-back control
//   mem_funct3, mem_addr_lo                 - load width/sign and byte lane
//   mem_alu_result, mem_load_data,
//   mem_pc_plus4, mem_imm                   - candidate results
//   reg_write, rd, write_data               - register-file write port
//   wb_valid                                - slot is retiring
//   instret                                 - retired count (WB_RETIRE_CNT_EN)

module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [XLEN-1:0] mem_imm,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data,
    output logic            wb_valid
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     instret
`endif
);

    logic            r_reg_write;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_write_data;
    logic            r_wb_valid;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_result;

    // Byte lane from addr_lo; halfword lane uses only addr_lo[1].
    always_comb begin
        w_byte = 8'h00;
        case (mem_addr_lo)
            2'd0:    w_byte = mem_load_data[7:0];
            2'd1:    w_byte = mem_load_data[15:8];
            2'd2:    w_byte = mem_load_data[23:16];
            default: w_byte = mem_load_data[31:24];
        endcase
        w_half = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    end

    always_comb begin
        w_load_val = mem_load_data;
        case (mem_funct3)
            3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_val = mem_load_data;
        endcase
    end

    always_comb begin
        w_result = mem_alu_result;
        case (mem_wb_sel)
            2'b00:   w_result = mem_alu_result;
            2'b01:   w_result = w_load_val;
            2'b10:   w_result = mem_pc_plus4;
            default: w_result = mem_imm;
        endcase
    end

    // Reset beats flush beats stall; capture only when neither is active.
    // rd/write_data are left untouched on flush since the slot is invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= 5'd0;
            r_write_data <= '0;
            r_wb_valid   <= 1'b0;
        end else if (flush) begin
            r_reg_write  <= 1'b0;
            r_wb_valid   <= 1'b0;
        end else if (!stall) begin
            r_reg_write  <= mem_valid & mem_reg_write & (mem_rd != 5'd0);
            r_rd         <= mem_rd;
            r_write_data <= w_result;
            r_wb_valid   <= mem_valid;
        end
    end

    assign reg_write  = r_reg_write;
    assign rd         = r_rd;
    assign write_data = r_write_data;
    assign wb_valid   = r_wb_valid;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_instret;

    // Counts captures of valid slots, so a stalled instruction counts once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instret <= 64'd0;
        end else if (!flush && !stall && mem_valid) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, stall, flush, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
`endif

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .stall(stall),
        .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .mem_imm(mem_imm), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .wb_valid(wb_valid)
`ifdef WB_RETIRE_CNT_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the architectural WB register should hold.
    logic        m_rw, m_v;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [63:0] m_cnt;

    function automatic logic [31:0] ref_result(
        input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
        input logic [31:0] alu, input logic [31:0] ld,
        input logic [31:0] pc4, input logic [31:0] imm);
        logic [31:0] v;
        int sh;
        case (sel)
            2'd0: return alu;
            2'd2: return pc4;
            2'd3: return imm;
            default: ;
        endcase
        if (f3 == 3'd0 || f3 == 3'd4) begin
            sh = int'(lo) * 8;
            v  = (ld >> sh) & 32'hFF;
            if (f3 == 3'd0 && v > 32'd127) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh = int'(lo[1]) * 16;
            v  = (ld >> sh) & 32'hFFFF;
            if (f3 == 3'd1 && v > 32'd32767) v = v - 32'd65536;
        end else begin
            v = ld;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_rw = 0; m_v = 0; m_rd = 0; m_wd = 0; m_cnt = 0;
        end else if (flush) begin
            m_rw = 0; m_v = 0;
        end else if (!stall) begin
            m_v  = mem_valid;
            m_rw = mem_valid && mem_reg_write && (mem_rd != 0);
            m_rd = mem_rd;
            m_wd = ref_result(mem_wb_sel, mem_funct3, mem_addr_lo, mem_alu_result,
                              mem_load_data, mem_pc_plus4, mem_imm);
            if (mem_valid) m_cnt = m_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".reg_write"}, 64'(reg_write), 64'(m_rw));
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_v));
        if (m_v) begin
            check({tag, ".rd"}, 64'(rd), 64'(m_rd));
            check({tag, ".write_data"}, 64'(write_data), 64'(m_wd));
        end
`ifdef WB_RETIRE_CNT_EN
        check({tag, ".instret"}, instret, m_cnt);
`endif
    endtask

    // Inputs change on the falling edge; one rising edge; then sample at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic [4:0] r,
                          input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] alu, input logic [31:0] ld,
                          input logic [31:0] pc4, input logic [31:0] imm);
        mem_valid = v; mem_reg_write = rw; mem_rd = r; mem_wb_sel = sel;
        mem_funct3 = f3; mem_addr_lo = lo; mem_alu_result = alu;
        mem_load_data = ld; mem_pc_plus4 = pc4; mem_imm = imm;
    endtask

    typedef struct {
        string       name;
        logic        v, rw;
        logic [4:0]  r;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] alu, ld, pc4, imm;
        logic        e_rw, e_v;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [63:0] c0;
        logic [4:0]  h_rd;
        logic [31:0] h_wd;

        vecs[0]  = '{"alu",    1,1,5, 2'd0,3'd0,2'd0, 32'h12345678,32'h0,32'h0,32'h0,        1,1,5, 32'h12345678};
        vecs[1]  = '{"lb3",    1,1,6, 2'd1,3'd0,2'd3, 32'h0,32'h80FF7F01,32'h0,32'h0,        1,1,6, 32'hFFFFFF80};
        vecs[2]  = '{"lbu3",   1,1,6, 2'd1,3'd4,2'd3, 32'h0,32'h80FF7F01,32'h0,32'h0,        1,1,6, 32'h00000080};
        vecs[3]  = '{"lh2",    1,1,7, 2'd1,3'd1,2'd2, 32'h0,32'h80017FFF,32'h0,32'h0,        1,1,7, 32'hFFFF8001};
        vecs[4]  = '{"lhu2",   1,1,7, 2'd1,3'd5,2'd2, 32'h0,32'h80017FFF,32'h0,32'h0,        1,1,7, 32'h00008001};
        vecs[5]  = '{"lb0",    1,1,8, 2'd1,3'd0,2'd0, 32'h0,32'h80FF7F01,32'h0,32'h0,        1,1,8, 32'h00000001};
        vecs[6]  = '{"lh1odd", 1,1,8, 2'd1,3'd1,2'd1, 32'h0,32'h80017FFF,32'h0,32'h0,        1,1,8, 32'h00007FFF};
        vecs[7]  = '{"lw3",    1,1,9, 2'd1,3'd2,2'd3, 32'h0,32'hDEADBEEF,32'h0,32'h0,        1,1,9, 32'hDEADBEEF};
        vecs[8]  = '{"f3_111", 1,1,9, 2'd1,3'd7,2'd1, 32'h0,32'hCAFEF00D,32'h0,32'h0,        1,1,9, 32'hCAFEF00D};
        vecs[9]  = '{"pc4",    1,1,1, 2'd2,3'd0,2'd0, 32'h0,32'h0,32'h00001004,32'h0,        1,1,1, 32'h00001004};
        vecs[10] = '{"imm",    1,1,31,2'd3,3'd0,2'd0, 32'h0,32'h0,32'h0,32'hABCDE000,        1,1,31,32'hABCDE000};
        vecs[11] = '{"x0",     1,1,0, 2'd0,3'd0,2'd0, 32'h55AA55AA,32'h0,32'h0,32'h0,        0,1,0, 32'h55AA55AA};

        reset = 0; stall = 0; flush = 0;
        set_in(1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h1111, 0, 0, 0);
        @(negedge clk);
        tick();
        check("reset.reg_write", 64'(reg_write), 64'd0);
        check("reset.rd", 64'(rd), 64'd0);
        check("reset.write_data", 64'(write_data), 64'd0);
        check("reset.wb_valid", 64'(wb_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("reset.instret", instret, 64'd0);
`endif
        // First edge out of reset with no valid instruction.
        set_in(0, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h2222, 0, 0, 0);
        reset = 1;
        tick();
        check("post_reset.reg_write", 64'(reg_write), 64'd0);
        check("post_reset.wb_valid", 64'(wb_valid), 64'd0);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
`ifdef WB_RETIRE_CNT_EN
            c0 = instret;
`endif
            set_in(vecs[i].v, vecs[i].rw, vecs[i].r, vecs[i].sel, vecs[i].f3, vecs[i].lo,
                   vecs[i].alu, vecs[i].ld, vecs[i].pc4, vecs[i].imm);
            tick();
            check({vecs[i].name, ".reg_write"}, 64'(reg_write), 64'(vecs[i].e_rw));
            check({vecs[i].name, ".wb_valid"}, 64'(wb_valid), 64'(vecs[i].e_v));
            check({vecs[i].name, ".rd"}, 64'(rd), 64'(vecs[i].e_rd));
            check({vecs[i].name, ".write_data"}, 64'(write_data), 64'(vecs[i].e_wd));
`ifdef WB_RETIRE_CNT_EN
            check({vecs[i].name, ".instret"}, instret, c0 + 64'd1);
`endif
        end

        // Stall three cycles, then flush while stalled.
        set_in(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h0BADF00D, 0, 0, 0);
        tick();
        h_rd = 5'd12; h_wd = 32'h0BADF00D;
`ifdef WB_RETIRE_CNT_EN
        c0 = instret;
`endif
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 5'(13 + i), 2'd3, 3'd0, 2'd0, 0, 0, 0, 32'h77770000 + i);
            tick();
            check("stall.reg_write", 64'(reg_write), 64'd1);
            check("stall.wb_valid", 64'(wb_valid), 64'd1);
            check("stall.rd", 64'(rd), 64'(h_rd));
            check("stall.write_data", 64'(write_data), 64'(h_wd));
`ifdef WB_RETIRE_CNT_EN
            check("stall.instret", instret, c0);
`endif
        end
        flush = 1;
        tick();
        check("flush.reg_write", 64'(reg_write), 64'd0);
        check("flush.wb_valid", 64'(wb_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("flush.instret", instret, c0);
`endif
        stall = 0; flush = 0;

        // Reset mid-stream after exactly seven retirements.
        reset = 0; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        for (int i = 0; i < 7; i++) begin
            set_in(1, 1, 5'(i + 1), 2'd0, 3'd0, 2'd0, 32'h100 + i, 0, 0, 0);
            tick();
        end
`ifdef WB_RETIRE_CNT_EN
        check("seven.instret", instret, 64'd7);
`endif
        reset = 0;
        tick();
        check("midreset.reg_write", 64'(reg_write), 64'd0);
        check("midreset.rd", 64'(rd), 64'd0);
        check("midreset.write_data", 64'(write_data), 64'd0);
        check("midreset.wb_valid", 64'(wb_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("midreset.instret", instret, 64'd0);

        // Counter wrap from all-ones.
        reset = 1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        set_in(1, 0, 5'd4, 2'd0, 3'd0, 2'd0, 0, 0, 0, 0);
        tick();
        check("wrap.instret", instret, 64'd0);
`endif

        // Randomized run against the reference model.
        reset = 1;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_in(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                   2'($urandom), $urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 7) == 0) mem_rd = 5'd0;
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port mem_valid  input  1  MEM/WB slot holds a real instruction.
REQ-005 SHALL have port stall  input  1  hold the current WB contents.
REQ-006 SHALL have port flush  input  1  squash the incoming slot.
REQ-007 SHALL have port mem_reg_write  input  1  instruction writes a register.
REQ-008 SHALL have port mem_rd  input  5  destination register index.
REQ-009 SHALL have port mem_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-010 SHALL have port mem_funct3  input  3  load width/sign code.
REQ-011 SHALL have port mem_addr_lo  input  2  load address bits [1:0].
REQ-012 SHALL have ports mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm  input  32 each  candidate results; load data is the raw aligned word.
REQ-013 SHALL have port reg_write  output  1  register-file write enable, driven to the decode stage.
REQ-014 SHALL have port rd  output  5  register-file write index.
REQ-015 SHALL have port write_data  output  32  register-file write value.
REQ-016 SHALL have port wb_valid  output  1  WB slot holds a retiring instruction.
REQ-017 SHALL have port instret  output  64  retired-instruction count (present only per REQ-033).

Function
REQ-018 SHALL register all outputs; an instruction presented at edge N appears on the outputs after edge N, a latency of one cycle.
REQ-019 SHALL capture all mem_* inputs when stall=0 and flush=0.
REQ-020 SHALL hold all outputs unchanged while stall=1 and flush=0.
REQ-021 SHALL clear wb_valid and reg_write when flush=1; flush has priority over stall, and rd and write_data are don't-care.
REQ-022 SHALL drive reg_write = mem_valid & mem_reg_write & (mem_rd != 0), so x0 is never written.
REQ-023 SHALL set write_data per mem_wb_sel: ALU result, aligned load value, pc_plus4, or imm.
REQ-024 SHALL select load bytes for mem_funct3 000 (LB) and 100 (LBU) from lane mem_addr_lo, sign-extending for LB and zero-extending for LBU.
REQ-025 SHALL select load halfwords for mem_funct3 001 (LH) and 101 (LHU) from lane mem_addr_lo[1], ignoring mem_addr_lo[0], sign-extending for LH and zero-extending for LHU.
REQ-026 SHALL, for mem_funct3 010 and every other code, pass the full word and ignore mem_addr_lo.
REQ-027 SHALL write back and retire exactly once an instruction that is held for several stall cycles.

Reset
REQ-028 SHALL, while reset=0 at a rising edge, clear reg_write, rd, write_data, wb_valid and instret (if present) to 0.
REQ-029 SHALL give reset priority over flush, stall and all captures; an instruction in flight at reset is discarded.
REQ-030 SHALL drive reg_write=0 on the first edge after reset deasserts unless a valid writing instruction is captured on that edge.

Configuration
REQ-031 SHALL provide macro WB_RETIRE_CNT_EN.
REQ-032 SHALL, when WB_RETIRE_CNT_EN is undefined, omit the instret port and its counter entirely.
REQ-033 SHALL, when WB_RETIRE_CNT_EN is defined, include instret, incrementing it by 1 on each edge where a new valid instruction is captured (stall=0, flush=0, mem_valid=1), independent of reg_write, wrapping 2^64-1 to 0.

Verification
REQ-034 SHALL verify: ALU op rd=5, result 0x1234_5678, wb_sel=00 -> next cycle reg_write=1, rd=5, write_data=0x1234_5678.
REQ-035 SHALL verify: LB, load_data=0x80FF_7F01, addr_lo=3 -> write_data=0xFFFF_FF80; LBU with addr_lo=3 -> 0x0000_0080.
REQ-036 SHALL verify: LH, load_data=0x8001_7FFF, addr_lo=2 -> 0xFFFF_8001; LHU with addr_lo=2 -> 0x0000_8001.
REQ-037 SHALL verify: mem_rd=0 with reg_write=1 and valid -> reg_write=0, wb_valid=1, instret +1.
REQ-038 SHALL verify: 3-cycle stall on a valid writing instruction, then flush with stall=1 -> outputs held for 3 cycles, then wb_valid=0 and reg_write=0; instret counts once.
REQ-039 SHALL verify: reset=0 asserted mid-stream with instret=7 -> all outputs 0 on the next edge; instret preloaded to 2^64-1 then one retire -> 0.
